fifo_wr_arbiter: RTL and testbench

- Shares one synchronous FIFO write port between CHANNELS independent producers.
- Each producer uses a req/ack handshake; the arbiter grants round-robin with bounded bursts and drives the FIFO's en_w/data_w.
- Write-side flow control comes from the FIFO's registered full flag.
- Sits between bus-side producers (UART RX, DMA, etc.) and the shared fifo instance.

---
 rtl/fifo_wr_arbiter.sv | 93 +++++++++
 tb/tb_fifo_wr_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter: shares one synchronous FIFO write port between
// CHANNELS req/ack producers, granting bounded bursts and honouring the FIFO full flag.
module fifo_wr_arbiter #(
    parameter int CHANNELS  = 4,
    parameter int DATA_BITS = 32,
    parameter int BURST_MAX = 4,
    parameter int CH_BITS   = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHANNELS-1:0]           req,
    input  logic [CHANNELS*DATA_BITS-1:0] data_in,
    output logic [CHANNELS-1:0]           ack,
    output logic                          fifo_en_w,
    output logic [DATA_BITS-1:0]          fifo_data_w,
    input  logic                          fifo_full_w,
    output logic [CH_BITS-1:0]            grant_id,
    output logic                          busy
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t             state;
    logic [7:0]         burst_cnt;
    logic               wr;
    logic               found;
    logic [CH_BITS-1:0] next_id;
    logic [CH_BITS-1:0] idx;

    // Search starts one past the last grant so every requester is reached within CHANNELS grants.
    always_comb begin
        found   = 1'b0;
        next_id = grant_id;
        idx     = '0;
        for (int unsigned k = 1; k <= CHANNELS; k++) begin
            idx = CH_BITS'((32'(grant_id) + k) % CHANNELS);
            if (!found && req[idx]) begin
                found   = 1'b1;
                next_id = idx;
            end
        end
    end

    assign wr          = ~rst & (state == GRANT) & req[grant_id] & ~fifo_full_w;
    assign fifo_en_w   = wr;
    assign fifo_data_w = data_in[32'(grant_id) * DATA_BITS +: DATA_BITS];

    always_comb begin
        ack = '0;
        if (wr) ack[grant_id] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            grant_id  <= CH_BITS'(CHANNELS - 1);
            burst_cnt <= '0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id  <= next_id;
                        burst_cnt <= '0;
                        state     <= GRANT;
                        busy      <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!req[grant_id]) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (wr) begin
                        if (burst_cnt == 8'(BURST_MAX - 1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            burst_cnt <= burst_cnt + 8'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed scoreboard bench for fifo_wr_arbiter: producer queues, a 7-entry FIFO
// model with registered full flag, and a cycle-level reference of the grant protocol.
module tb_fifo_wr_arbiter;

    localparam int CH    = 4;
    localparam int DW    = 32;
    localparam int BM    = 4;
    localparam int CB    = 2;
    localparam int DEPTH = 7;

    logic             clk = 1'b0;
    logic             rst;
    logic [CH-1:0]    req;
    logic [CH*DW-1:0] data_in;
    logic [CH-1:0]    ack;
    logic             fifo_en_w;
    logic [DW-1:0]    fifo_data_w;
    logic             fifo_full_w;
    logic [CB-1:0]    grant_id;
    logic             busy;

    always #5 clk = ~clk;

    fifo_wr_arbiter #(
        .CHANNELS (CH),
        .DATA_BITS(DW),
        .BURST_MAX(BM),
        .CH_BITS  (CB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data_in    (data_in),
        .ack        (ack),
        .fifo_en_w  (fifo_en_w),
        .fifo_data_w(fifo_data_w),
        .fifo_full_w(fifo_full_w),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [DW-1:0] prod_q[CH][$];
    logic [DW-1:0] exp_q[CH][$];
    logic [DW-1:0] fifo_q[$];
    int            grant_log[$];
    int            burst_log[$];
    int            first_wr, last_wr, wr_total;
    bit            rd_en, rd_once;
    bit            m_busy;
    int            m_gid, m_cnt;
    logic [CH-1:0] s_ack;
    logic          s_en;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void drive();
        for (int i = 0; i < CH; i++) begin
            req[i] = (prod_q[i].size() > 0);
            data_in[i*DW +: DW] = req[i] ? prod_q[i][0] : '0;
        end
    endfunction

    function automatic bit all_empty();
        bit e = 1'b1;
        for (int i = 0; i < CH; i++) if (prod_q[i].size() != 0) e = 1'b0;
        return e;
    endfunction

    task automatic step();
        logic          exp_wr;
        logic [CH-1:0] exp_ack;
        bit            found;
        int            base;
        @(negedge clk);
        exp_wr  = !rst && m_busy && req[m_gid] && !fifo_full_w;
        exp_ack = '0;
        if (exp_wr) exp_ack[m_gid] = 1'b1;
        chk("ack", 64'(ack), 64'(exp_ack));
        chk("en_w", 64'(fifo_en_w), 64'(exp_wr));
        chk("grant_id", 64'(grant_id), 64'(m_gid));
        chk("busy", 64'(busy), 64'(m_busy));
        chk("ack_onehot0", 64'($onehot0(ack)), 64'(1));
        s_ack = ack;
        s_en  = fifo_en_w;
        if (fifo_en_w === 1'b1) begin
            if (exp_q[grant_id].size() == 0) begin
                checks++;
                errors++;
                $error("FAIL sb_spurious_write: observed data %0h on channel %0d expected no write",
                       fifo_data_w, grant_id);
            end else begin
                chk("wr_data", 64'(fifo_data_w), 64'(exp_q[grant_id].pop_front()));
            end
            fifo_q.push_back(fifo_data_w);
            if (burst_log.size() > 0) burst_log[burst_log.size()-1]++;
            if (wr_total == 0) first_wr = cyc;
            last_wr = cyc;
            wr_total++;
        end
        // reference arbiter next state
        if (rst) begin
            m_busy = 1'b0;
            m_gid  = CH - 1;
            m_cnt  = 0;
        end else if (!m_busy) begin
            found = 1'b0;
            base  = m_gid;
            for (int k = 1; k <= CH; k++) begin
                int i2 = (base + k) % CH;
                if (!found && req[i2]) begin
                    found = 1'b1;
                    m_gid = i2;
                end
            end
            if (found) begin
                m_busy = 1'b1;
                m_cnt  = 0;
                grant_log.push_back(m_gid);
                burst_log.push_back(0);
            end
        end else if (!req[m_gid]) begin
            m_busy = 1'b0;
        end else if (exp_wr) begin
            if (m_cnt == BM - 1) m_busy = 1'b0;
            else m_cnt++;
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < CH; i++) if (s_ack[i] === 1'b1) void'(prod_q[i].pop_front());
        if ((rd_en || rd_once) && fifo_q.size() > 0) void'(fifo_q.pop_front());
        rd_once     = 1'b0;
        fifo_full_w = (fifo_q.size() >= DEPTH);
        drive();
        cyc++;
    endtask

    task automatic load(input int ch, input logic [DW-1:0] base, input int n);
        for (int j = 0; j < n; j++) begin
            prod_q[ch].push_back(base + DW'(j));
            exp_q[ch].push_back(base + DW'(j));
        end
        drive();
    endtask

    task automatic clear_logs();
        grant_log.delete();
        burst_log.delete();
        wr_total = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        clear_logs();
        chk("rst_grant_id", 64'(grant_id), 64'(CH - 1));
        chk("rst_busy", 64'(busy), 64'(0));
    endtask

    task automatic drain(input int max, input string tag);
        int n = 0;
        int left = 0;
        while (n < max && !(all_empty() && !m_busy)) begin
            step();
            n++;
        end
        chk({tag, "_done"}, 64'(all_empty() && !m_busy), 64'(1));
        for (int i = 0; i < CH; i++) left += exp_q[i].size();
        chk({tag, "_sb_left"}, 64'(left), 64'(0));
    endtask

    initial begin
        int n;
        int w0;
        rst = 1'b1;
        req = '0;
        data_in = '0;
        fifo_full_w = 1'b0;
        rd_en = 1'b1;
        rd_once = 1'b0;
        m_busy = 1'b0;
        m_gid = CH - 1;
        m_cnt = 0;
        wr_total = 0;
        first_wr = 0;
        last_wr = 0;

        // reset state
        do_reset();
        chk("rst_ack", 64'(ack), 64'(0));
        chk("rst_en_w", 64'(fifo_en_w), 64'(0));

        // single channel streaming 10 words
        load(2, 32'h100, 10);
        drain(60, "single");
        chk("single_ngrants", 64'(grant_log.size()), 64'(3));
        for (int i = 0; i < 3; i++) chk("single_gid", 64'(grant_log[i]), 64'(2));
        chk("single_b0", 64'(burst_log[0]), 64'(4));
        chk("single_b1", 64'(burst_log[1]), 64'(4));
        chk("single_b2", 64'(burst_log[2]), 64'(2));
        chk("single_span", 64'(last_wr - first_wr), 64'(11));
        chk("single_grant_id", 64'(grant_id), 64'(2));

        // all four channels requesting continuously
        do_reset();
        for (int c = 0; c < CH; c++) load(c, 32'h1000 * (c + 1), 8);
        drain(100, "all4");
        chk("all4_ngrants", 64'(grant_log.size()), 64'(8));
        for (int i = 0; i < 8; i++) begin
            chk("all4_order", 64'(grant_log[i]), 64'(i % CH));
            chk("all4_burst", 64'(burst_log[i]), 64'(BM));
        end

        // FIFO full back-pressure
        do_reset();
        rd_en = 1'b0;
        load(1, 32'h1100, 12);
        n = 0;
        while (fifo_q.size() < DEPTH && n < 40) begin
            step();
            n++;
        end
        chk("full_fill", 64'(fifo_q.size()), 64'(DEPTH));
        repeat (3) step();
        chk("full_stall", 64'(fifo_q.size()), 64'(DEPTH));
        w0 = wr_total;
        rd_once = 1'b1;
        repeat (4) step();
        chk("full_one_release", 64'(wr_total - w0), 64'(1));
        rd_en = 1'b1;
        drain(100, "full");
        chk("full_total", 64'(wr_total), 64'(12));

        // early release by channel 0
        do_reset();
        load(0, 32'h2000, 2);
        load(3, 32'h2300, 3);
        drain(40, "early");
        chk("early_ngrants", 64'(grant_log.size()), 64'(2));
        chk("early_g0", 64'(grant_log[0]), 64'(0));
        chk("early_g1", 64'(grant_log[1]), 64'(3));
        chk("early_b0", 64'(burst_log[0]), 64'(2));
        chk("early_b1", 64'(burst_log[1]), 64'(3));

        // reset in the second write cycle of channel 2
        do_reset();
        load(2, 32'h3200, 6);
        load(3, 32'h3300, 2);
        n = 0;
        while (wr_total < 1 && n < 20) begin
            step();
            n++;
        end
        chk("rstmid_first_write", 64'(wr_total), 64'(1));
        rst = 1'b1;
        step();
        chk("rstmid_en_gated", 64'(s_en), 64'(0));
        chk("rstmid_ack_gated", 64'(s_ack), 64'(0));
        rst = 1'b0;
        clear_logs();
        chk("rstmid_grant_id", 64'(grant_id), 64'(CH - 1));
        drain(60, "rstmid");
        chk("rstmid_ngrants", 64'(grant_log.size()), 64'(3));
        chk("rstmid_g0", 64'(grant_log[0]), 64'(2));
        chk("rstmid_g1", 64'(grant_log[1]), 64'(3));
        chk("rstmid_g2", 64'(grant_log[2]), 64'(2));
        chk("rstmid_b0", 64'(burst_log[0]), 64'(4));
        chk("rstmid_b1", 64'(burst_log[1]), 64'(2));
        chk("rstmid_b2", 64'(burst_log[2]), 64'(1));

        // round-robin wrap from channel 3 to channel 0
        do_reset();
        load(3, 32'h4300, 4);
        drain(30, "wrap_a");
        chk("wrap_a_g0", 64'(grant_log[0]), 64'(3));
        chk("wrap_a_grant_id", 64'(grant_id), 64'(3));
        clear_logs();
        load(0, 32'h4000, 2);
        load(3, 32'h4310, 2);
        drain(30, "wrap_b");
        chk("wrap_b_ngrants", 64'(grant_log.size()), 64'(2));
        chk("wrap_b_g0", 64'(grant_log[0]), 64'(0));
        chk("wrap_b_g1", 64'(grant_log[1]), 64'(3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no completion expected finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule
